// File: rtl/imem_loader.sv
// +--------------------------------------------------------------------------+
// | imem_loader: assembles a little-endian byte stream into instruction     |
// | words, writes them to instruction memory and gates the CPU reset. r1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_loader #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic             clk,
  input  logic             a_reset_n,
  input  logic             i_start,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic             o_byte_ready,
  output logic             o_we,
  output logic [WIDTH-1:0] o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_cpu_reset_n,
  output logic             o_busy,
  output logic             o_load_done,
  output logic             o_error,
  output logic [15:0]      o_word_count
);

  localparam logic [15:0] LAST_IDX = 16'(DEPTH_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  // Word index and session word count always move together, so one register serves both.
  logic [15:0] word_idx;
  logic        cpu_rst_n;
  logic        accept;
  logic        start_session;

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    o_byte_ready  = 1'b0;
    o_we          = 1'b0;
    o_busy        = 1'b0;
    o_load_done   = 1'b0;
    o_error       = 1'b0;
    o_waddr       = '0;
    o_wdata       = '0;
    accept        = 1'b0;
    start_session = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt     = RECV;
          start_session = 1'b1;
        end
      end
      RECV: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        accept       = i_byte_valid;
        if (i_byte_valid && (byte_idx == 2'd3)) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        o_we    = 1'b1;
        o_busy  = 1'b1;
        o_waddr = WIDTH'({word_idx, 2'b00});
        o_wdata = WIDTH'(word);
        // A zero word terminates the load even when it is also the last slot.
        if (word == 32'd0) begin
          state_nxt = DONE;
        end else if (word_idx == LAST_IDX) begin
          state_nxt = ERR;
        end else begin
          state_nxt = RECV;
        end
      end
      DONE: begin
        o_load_done = 1'b1;
        if (i_start) begin
          state_nxt     = RECV;
          start_session = 1'b1;
        end
      end
      ERR: begin
        o_error = 1'b1;
        if (i_start) begin
          state_nxt     = RECV;
          start_session = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      byte_idx  <= 2'd0;
      word      <= 32'd0;
      word_idx  <= 16'd0;
      cpu_rst_n <= 1'b0;
    end else begin
      // Registered so the core reset never glitches; only a clean load releases it.
      cpu_rst_n <= (state_nxt == DONE);
      if (start_session) begin
        byte_idx <= 2'd0;
        word     <= 32'd0;
        word_idx <= 16'd0;
      end else begin
        if (accept) begin
          word[{byte_idx, 3'b000} +: 8] <= i_byte;
          byte_idx                      <= byte_idx + 2'd1;
        end
        if (state == WRITE) begin
          word_idx <= word_idx + 16'd1;
        end
      end
    end
  end

  assign o_cpu_reset_n = cpu_rst_n;
  assign o_word_count  = word_idx;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +--------------------------------------------------------------------------+
// | tb_imem_loader: directed self-checking bench for imem_loader (256 and    |
// | 4-word instances). r1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        a_reset_n = 1'b0;

  logic        start0 = 1'b0, valid0 = 1'b0;
  logic [7:0]  byte0 = 8'h00;
  logic        ready0, we0, cpurst0, busy0, done0, err0;
  logic [31:0] waddr0, wdata0;
  logic [15:0] cnt0;

  logic        start1 = 1'b0, valid1 = 1'b0;
  logic [7:0]  byte1 = 8'h00;
  logic        ready1, we1, cpurst1, busy1, done1, err1;
  logic [31:0] waddr1, wdata1;
  logic [15:0] cnt1;

  int checks = 0;
  int fails  = 0;

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];

  always #5 clk = ~clk;

  imem_loader #(.WIDTH(32), .DEPTH_WORDS(256)) dut (
    .clk(clk), .a_reset_n(a_reset_n), .i_start(start0), .i_byte_valid(valid0),
    .i_byte(byte0), .o_byte_ready(ready0), .o_we(we0), .o_waddr(waddr0),
    .o_wdata(wdata0), .o_cpu_reset_n(cpurst0), .o_busy(busy0),
    .o_load_done(done0), .o_error(err0), .o_word_count(cnt0)
  );

  imem_loader #(.WIDTH(32), .DEPTH_WORDS(4)) dut4 (
    .clk(clk), .a_reset_n(a_reset_n), .i_start(start1), .i_byte_valid(valid1),
    .i_byte(byte1), .o_byte_ready(ready1), .o_we(we1), .o_waddr(waddr1),
    .o_wdata(wdata1), .o_cpu_reset_n(cpurst1), .o_busy(busy1),
    .o_load_done(done1), .o_error(err1), .o_word_count(cnt1)
  );

  // Write-strobe monitor: logs every memory write of both instances.
  always @(negedge clk) begin
    if (we0 === 1'b1) begin wa0.push_back(waddr0); wd0.push_back(wdata0); end
    if (we1 === 1'b1) begin wa1.push_back(waddr1); wd1.push_back(wdata1); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n = 0;
    if (sel) begin valid1 = 1'b1; byte1 = b; end
    else     begin valid0 = 1'b1; byte0 = b; end
    @(negedge clk);
    while (((sel ? ready1 : ready0) !== 1'b1) && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      checks++; fails++;
      $display("FAIL send_byte_timeout: ready stayed low for byte %h (sel %0d)", b, sel);
    end
    @(posedge clk); #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(sel, w[8*i +: 8]);
  endtask

  task automatic test_reset();
    a_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({we0, waddr0, wdata0, ready0, cpurst0, busy0, done0, err0, cnt0} !== 88'd0) begin
      fails++;
      $display("FAIL reset_outputs_256: got %h expected 0",
               {we0, waddr0, wdata0, ready0, cpurst0, busy0, done0, err0, cnt0});
    end
    checks++;
    if ({we1, waddr1, wdata1, ready1, cpurst1, busy1, done1, err1, cnt1} !== 88'd0) begin
      fails++;
      $display("FAIL reset_outputs_4: got %h expected 0",
               {we1, waddr1, wdata1, ready1, cpurst1, busy1, done1, err1, cnt1});
    end
    @(posedge clk); #1;
    a_reset_n = 1'b1;
    valid0 = 1'b1;
    byte0  = 8'h55;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready0, busy0, cpurst0} !== 3'b000 || wa0.size() !== 0) begin
      fails++;
      $display("FAIL idle_without_start: ready/busy/cpurst %b writes %0d expected 000 and 0",
               {ready0, busy0, cpurst0}, wa0.size());
    end
    @(posedge clk); #1;
    valid0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    wa0.delete(); wd0.delete();
    pulse_start(0);
    @(negedge clk);
    checks++;
    if ({busy0, ready0, cpurst0, cnt0} !== {3'b110, 16'd0}) begin
      fails++;
      $display("FAIL first_recv_cycle: busy/ready/cpurst %b cnt %0d expected 110 and 0",
               {busy0, ready0, cpurst0}, cnt0);
    end
    @(posedge clk); #1;
    send_word(0, 32'h00000513);
    send_word(0, 32'h00000000);
    repeat (2) @(negedge clk);
    checks++;
    if (wa0.size() !== 2) begin
      fails++; $display("FAIL b2b_write_count: got %0d expected 2", wa0.size());
    end
    checks++;
    if ({wa0[0], wd0[0]} !== {32'h0, 32'h00000513}) begin
      fails++; $display("FAIL b2b_write0: got %h/%h expected 0/00000513", wa0[0], wd0[0]);
    end
    checks++;
    if ({wa0[1], wd0[1]} !== {32'h4, 32'h0}) begin
      fails++; $display("FAIL b2b_write1: got %h/%h expected 4/0", wa0[1], wd0[1]);
    end
    checks++;
    if ({done0, err0, busy0, cpurst0, cnt0} !== {4'b1001, 16'd2}) begin
      fails++;
      $display("FAIL b2b_done_state: done/err/busy/cpurst %b cnt %0d expected 1001 and 2",
               {done0, err0, busy0, cpurst0}, cnt0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gapped();
    logic [31:0] w = 32'h00100093;
    wa0.delete(); wd0.delete();
    pulse_start(0);
    for (int i = 0; i < 4; i++) begin
      send_byte(0, w[8*i +: 8]);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          checks++;
          if (ready0 !== 1'b1) begin
            fails++; $display("FAIL gap_ready: got %b expected 1 (byte %0d gap %0d)", ready0, i, g);
          end
          @(posedge clk); #1;
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wa0.size() !== 1 || wd0[0] !== 32'h00100093 || wa0[0] !== 32'h0) begin
      fails++;
      $display("FAIL gapped_write: count %0d data %h addr %h expected 1/00100093/0",
               wa0.size(), wd0[0], wa0[0]);
    end
    checks++;
    if ({busy0, cnt0} !== {1'b1, 16'd1}) begin
      fails++; $display("FAIL gapped_progress: busy %b cnt %0d expected 1 and 1", busy0, cnt0);
    end
    @(posedge clk); #1;
    send_word(0, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_capacity_err();
    wa1.delete(); wd1.delete();
    pulse_start(1);
    send_word(1, 32'h00000093);
    send_word(1, 32'h00100113);
    send_word(1, 32'h00208193);
    send_word(1, 32'h12345678);
    repeat (2) @(negedge clk);
    checks++;
    if (wa1.size() !== 4 || wa1[3] !== 32'hC || wd1[3] !== 32'h12345678) begin
      fails++;
      $display("FAIL cap_last_write: count %0d addr %h data %h expected 4/c/12345678",
               wa1.size(), wa1[3], wd1[3]);
    end
    checks++;
    if ({err1, done1, cpurst1, ready1, busy1, cnt1} !== {5'b10000, 16'd4}) begin
      fails++;
      $display("FAIL cap_err_state: err/done/cpurst/ready/busy %b cnt %0d expected 10000 and 4",
               {err1, done1, cpurst1, ready1, busy1}, cnt1);
    end
    @(posedge clk); #1;
    valid1 = 1'b1;
    byte1  = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if (wa1.size() !== 4 || cnt1 !== 16'd4 || err1 !== 1'b1) begin
      fails++;
      $display("FAIL err_ignores_bytes: writes %0d cnt %0d err %b expected 4/4/1",
               wa1.size(), cnt1, err1);
    end
    @(posedge clk); #1;
    valid1 = 1'b0;
  endtask

  task automatic test_terminator_priority();
    wa1.delete(); wd1.delete();
    pulse_start(1);
    @(negedge clk);
    checks++;
    if ({err1, busy1, cnt1} !== {2'b01, 16'd0}) begin
      fails++;
      $display("FAIL restart_from_err: err/busy %b cnt %0d expected 01 and 0", {err1, busy1}, cnt1);
    end
    @(posedge clk); #1;
    send_word(1, 32'h11111111);
    send_word(1, 32'h22222222);
    send_word(1, 32'h33333333);
    send_word(1, 32'h00000000);
    repeat (2) @(negedge clk);
    checks++;
    if ({done1, err1, cpurst1, cnt1} !== {3'b101, 16'd4} || wa1[3] !== 32'hC || wd1[3] !== 32'h0) begin
      fails++;
      $display("FAIL term_priority: done/err/cpurst %b cnt %0d addr %h data %h expected 101/4/c/0",
               {done1, err1, cpurst1}, cnt1, wa1[3], wd1[3]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    wa0.delete(); wd0.delete();
    pulse_start(0);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    a_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({we0, waddr0, wdata0, ready0, cpurst0, busy0, done0, err0, cnt0} !== 88'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {we0, waddr0, wdata0, ready0, cpurst0, busy0, done0, err0, cnt0});
    end
    @(posedge clk); #1;
    a_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, ready0} !== 2'b00 || wa0.size() !== 0) begin
      fails++;
      $display("FAIL after_mid_reset: busy/ready %b writes %0d expected 00 and 0",
               {busy0, ready0}, wa0.size());
    end
    @(posedge clk); #1;
    pulse_start(0);
    send_word(0, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    checks++;
    if (wa0.size() !== 1 || wa0[0] !== 32'h0 || wd0[0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL post_reset_write: count %0d addr %h data %h expected 1/0/deadbeef",
               wa0.size(), wa0[0], wd0[0]);
    end
    @(posedge clk); #1;
    send_word(0, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    wa0.delete(); wd0.delete();
    pulse_start(0);
    send_byte(0, 8'h01);
    pulse_start(0);
    send_byte(0, 8'h02);
    send_byte(0, 8'h03);
    send_byte(0, 8'h04);
    repeat (2) @(negedge clk);
    checks++;
    if (wa0.size() !== 1 || wa0[0] !== 32'h0 || wd0[0] !== 32'h04030201 || cnt0 !== 16'd1) begin
      fails++;
      $display("FAIL start_in_recv: count %0d addr %h data %h cnt %0d expected 1/0/04030201/1",
               wa0.size(), wa0[0], wd0[0], cnt0);
    end
    @(posedge clk); #1;
    send_word(0, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if ({done0, cnt0} !== {1'b1, 16'd2}) begin
      fails++; $display("FAIL start_ign_done: done %b cnt %0d expected 1 and 2", done0, cnt0);
    end
    @(posedge clk); #1;
    pulse_start(0);
    @(negedge clk);
    checks++;
    if ({done0, cpurst0, busy0, cnt0} !== {3'b001, 16'd0}) begin
      fails++;
      $display("FAIL restart_from_done: done/cpurst/busy %b cnt %0d expected 001 and 0",
               {done0, cpurst0, busy0}, cnt0);
    end
    @(posedge clk); #1;
    send_word(0, 32'h000000AA);
    repeat (2) @(negedge clk);
    checks++;
    if (wa0.size() !== 3 || wa0[2] !== 32'h0 || wd0[2] !== 32'h000000AA) begin
      fails++;
      $display("FAIL restart_addr0: count %0d addr %h data %h expected 3/0/000000aa",
               wa0.size(), wa0[2], wd0[2]);
    end
    @(posedge clk); #1;
    send_word(0, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_capacity_err();
    test_terminator_priority();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
